// File: rtl/circ_shift_reg_16bits_pkg.sv
// Shared constants for the rotating pattern generator: default length and
// reference waveforms.
package circ_shift_reg_16bits_pkg;

  localparam int DEF_WIDTH = 16;

  // 11 cycles high, 5 low
  localparam logic [DEF_WIDTH-1:0] PAT_11_5 = 16'hFFE0;
  // single one-cycle pulse every 16 clocks
  localparam logic [DEF_WIDTH-1:0] PAT_1_15 = 16'h8000;

endpackage

// File: rtl/circ_shift_reg_16bits.sv
// Parallel-load circular shift register; the MSB is the serial output, so a
// loaded pattern becomes a periodic pulse/gap waveform of period WIDTH.
module circ_shift_reg_16bits
  import circ_shift_reg_16bits_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit ROTATE_LEFT = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_in,
  output logic             shift_out,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] pat_d;
  logic [WIDTH-1:0] rot_w;

  generate
    if (ROTATE_LEFT) begin : g_rot_left
      assign rot_w = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
    end else begin : g_rot_right
      assign rot_w = {pat_q[0], pat_q[WIDTH-1:1]};
    end
  endgenerate

  // Load wins over rotate; load_in is not looked at unless load is high.
  always_comb begin
    pat_d = rot_w;
    if (load) begin
      pat_d = load_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= '0;
    end else begin
      pat_q <= pat_d;
    end
  end

  assign shift_out = pat_q[WIDTH-1];
  assign q         = pat_q;

endmodule

// File: tb/tb_circ_shift_reg_16bits.sv
// Randomized and directed bench for circ_shift_reg_16bits against a
// pattern-plus-phase reference model.
module tb_circ_shift_reg_16bits;
  import circ_shift_reg_16bits_pkg::*;

  localparam int W = 16;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b1;
  logic         load    = 1'b0;
  logic [W-1:0] load_in = '0;
  logic         shift_out;
  logic [W-1:0] q;

  int total = 0;
  int bad   = 0;

  // Reference: the last loaded pattern and how many rotations since.
  logic [W-1:0] m_pat = '0;
  int           m_k   = 0;

  circ_shift_reg_16bits #(.WIDTH(W), .ROTATE_LEFT(1'b1)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .load_in  (load_in),
    .shift_out(shift_out),
    .q        (q)
  );

  always #5 clock = ~clock;

  // Left rotation by k: bit b of the pattern now sits at position (b+k) mod W.
  function automatic logic [W-1:0] model_q();
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) r[(b + m_k) % W] = m_pat[b];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [W-1:0] e;
    @(posedge clock);
    if (load) begin
      m_pat = load_in;
      m_k   = 0;
    end else begin
      m_k = (m_k + 1) % W;
    end
    #1;
    e = model_q();
    chk({tag, "_q"}, 32'(q), 32'(e));
    chk({tag, "_so"}, 32'(shift_out), 32'(e[W-1]));
  endtask

  // Called just after a rising edge; pulses reset low without any edge.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    m_pat = '0;
    m_k   = 0;
    chk({tag, "_rst_q"}, 32'(q), 32'h0);
    chk({tag, "_rst_so"}, 32'(shift_out), 32'h0);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic load_pat(input logic [W-1:0] p, input string tag);
    load_in = p;
    load    = 1'b1;
    tick(tag);
    load    = 1'b0;
  endtask

  initial begin
    int ones;
    logic [W-1:0] pats [2];

    // Known non-zero state, then asynchronous clear while load is requested.
    load_in = 16'hFFFF;
    load    = 1'b1;
    tick("init");
    reset_n = 1'b0;
    #1;
    m_pat = '0;
    m_k   = 0;
    chk("async_q", 32'(q), 32'h0);
    chk("async_so", 32'(shift_out), 32'h0);
    @(posedge clock);
    #1;
    chk("rst_hold_q", 32'(q), 32'h0);
    #2;
    reset_n = 1'b1;
    load    = 1'b0;
    tick("post_rst");

    // 11 high / 5 low, twice, with q back at the pattern every 16 rotates.
    load_pat(PAT_11_5, "p115_ld");
    chk("p115_0", 32'(shift_out), 32'h1);
    for (int i = 1; i <= 32; i++) begin
      tick("p115_rot");
      chk("p115_wave", 32'(shift_out), 32'((i % 16) < 11));
      if (i == 16 || i == 32) chk("p115_period", 32'(q), 32'hFFE0);
    end

    // One-cycle pulse per period.
    load_pat(PAT_1_15, "p1_ld");
    ones = 0;
    for (int i = 1; i <= 16; i++) begin
      tick("p1_rot");
      ones += int'(shift_out);
      if (i == 1) chk("p1_r1", 32'(q), 32'h0001);
      if (i == 4) chk("p1_r4", 32'(q), 32'h0008);
    end
    chk("p1_ones", 32'(ones), 32'd1);

    // Reload mid-sequence restarts the phase from the new MSB.
    load_pat(16'hFFE0, "rl_ld");
    for (int i = 0; i < 3; i++) tick("rl_rot");
    chk("rl_ff07", 32'(q), 32'hFF07);
    load_pat(16'h00FF, "rl_ld2");
    chk("rl_00ff", 32'(q), 32'h00FF);
    chk("rl_so0", 32'(shift_out), 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick("rl_rot2");
      chk("rl_low", 32'(shift_out), 32'h0);
    end
    tick("rl_rot3");
    chk("rl_high", 32'(shift_out), 32'h1);

    // Held load freezes rotation.
    load_in = 16'hA5A5;
    load    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("held");
      chk("held_q", 32'(q), 32'hA5A5);
    end
    load = 1'b0;

    // Reset mid-run clears the pattern and it stays clear.
    load_pat(PAT_11_5, "mr_ld");
    for (int i = 0; i < 7; i++) tick("mr_rot");
    async_reset("mr");
    for (int i = 0; i < 3; i++) begin
      tick("mr_after");
      chk("mr_zero", 32'(q), 32'h0);
    end

    // Uniform patterns are invariant under rotation.
    pats[0] = 16'hFFFF;
    pats[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      load_pat(pats[p], "uni_ld");
      for (int i = 0; i < 20; i++) begin
        tick("uni_rot");
        chk("uni_q", 32'(q), 32'(pats[p]));
        chk("uni_so", 32'(shift_out), 32'(pats[p][W-1]));
      end
    end

    // Random mix of loads, rotations (with junk on load_in) and resets.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) async_reset("rnd");
      load    = (r < 3);
      load_in = W'($urandom);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
